// File: rtl/foreground_prefetch_scheduler.sv
// Raster timing generator that requests one foreground prefetch per visible line, one
// line ahead of the beam, and counts the requests dropped because the unit was busy.

module foreground_prefetch_scheduler_chk #(
  parameter int H_TOTAL = 320,
  parameter int V_TOTAL = 262
) (
  input logic       gpu_clk,
  input logic       rst_n,
  input logic [8:0] h,
  input logic [8:0] v,
  input logic       start,
  input logic [7:0] start_y,
  input logic       drop
);
  // A slot resolves to a request or a drop, never both.
  a_start_drop_exclusive: assert property (@(posedge gpu_clk) disable iff (!rst_n)
    !(start && drop));

  a_y_zero_when_idle: assert property (@(posedge gpu_clk) disable iff (!rst_n)
    (start || (start_y == 8'd0)));

  a_h_in_range: assert property (@(posedge gpu_clk) disable iff (!rst_n)
    (int'(h) < H_TOTAL));

  a_v_in_range: assert property (@(posedge gpu_clk) disable iff (!rst_n)
    (int'(v) < V_TOTAL));
endmodule

module foreground_prefetch_scheduler #(
  parameter int H_VISIBLE = 256,
  parameter int H_FRONT   = 8,
  parameter int H_SYNC    = 32,
  parameter int H_BACK    = 24,
  parameter int V_VISIBLE = 240,
  parameter int V_FRONT   = 3,
  parameter int V_SYNC    = 4,
  parameter int V_BACK    = 15
) (
  input  logic       gpu_clk,
  input  logic       rst_n,
  input  logic       prefetch_busy_i,
  output logic       prefetch_start_o,
  output logic [7:0] prefetch_y_o,
  output logic [7:0] display_x_o,
  output logic [7:0] display_y_o,
  output logic       visible_o,
  output logic       hsync_o,
  output logic       vsync_o,
  output logic       drop_o,
  output logic [7:0] drop_count_o
);
  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [8:0] H_LAST       = 9'(H_TOTAL - 1);
  localparam logic [8:0] H_VIS        = 9'(H_VISIBLE);
  localparam logic [8:0] H_SYNC_BEGIN = 9'(H_VISIBLE + H_FRONT);
  localparam logic [8:0] H_SYNC_END   = 9'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [8:0] V_LAST       = 9'(V_TOTAL - 1);
  localparam logic [8:0] V_VIS        = 9'(V_VISIBLE);
  localparam logic [8:0] V_SYNC_BEGIN = 9'(V_VISIBLE + V_FRONT);
  localparam logic [8:0] V_SYNC_END   = 9'(V_VISIBLE + V_FRONT + V_SYNC);
  // Lines below this bound still have a visible successor to fetch.
  localparam logic [8:0] V_SLOT_BOUND = 9'(V_VISIBLE - 1);
  localparam logic [7:0] DROP_MAX     = 8'hFF;

  logic [8:0] h_r;
  logic [8:0] v_r;
  logic [7:0] drop_count_r;

  logic       h_wrap_s;
  logic       v_wrap_s;
  logic       visible_s;
  logic [7:0] x_s;
  logic [7:0] y_s;
  logic       hsync_s;
  logic       vsync_s;
  logic       slot_s;
  logic [7:0] target_s;
  logic       start_s;
  logic       drop_s;
  logic [7:0] prefetch_y_s;

  // End-of-line and end-of-frame detection
  always_comb begin
    h_wrap_s = (h_r == H_LAST);
    v_wrap_s = (v_r == V_LAST);
  end

  // Beam position counters
  always_ff @(posedge gpu_clk or negedge rst_n) begin
    if (!rst_n) begin
      h_r <= 9'd0;
      v_r <= 9'd0;
    end else if (h_wrap_s) begin
      h_r <= 9'd0;
      if (v_wrap_s) begin
        v_r <= 9'd0;
      end else begin
        v_r <= v_r + 9'd1;
      end
    end else begin
      h_r <= h_r + 9'd1;
      v_r <= v_r;
    end
  end

  // Raster decode straight from the counters so the beam outputs carry no latency
  always_comb begin
    visible_s = 1'b0;
    x_s       = 8'd0;
    y_s       = 8'd0;
    hsync_s   = 1'b1;
    vsync_s   = 1'b1;
    visible_s = (h_r < H_VIS) && (v_r < V_VIS);
    if (visible_s) begin
      x_s = h_r[7:0];
      y_s = v_r[7:0];
    end else begin
      x_s = 8'd0;
      y_s = 8'd0;
    end
    if ((h_r >= H_SYNC_BEGIN) && (h_r < H_SYNC_END)) begin
      hsync_s = 1'b0;
    end else begin
      hsync_s = 1'b1;
    end
    if ((v_r >= V_SYNC_BEGIN) && (v_r < V_SYNC_END)) begin
      vsync_s = 1'b0;
    end else begin
      vsync_s = 1'b1;
    end
  end

  // Slot at the first blanking pixel; the last line of the frame fetches line 0
  always_comb begin
    slot_s       = 1'b0;
    target_s     = 8'd0;
    start_s      = 1'b0;
    drop_s       = 1'b0;
    prefetch_y_s = 8'd0;
    if (h_r == H_VIS) begin
      if (v_r < V_SLOT_BOUND) begin
        slot_s   = 1'b1;
        target_s = v_r[7:0] + 8'd1;
      end else if (v_wrap_s) begin
        slot_s   = 1'b1;
        target_s = 8'd0;
      end else begin
        slot_s   = 1'b0;
        target_s = 8'd0;
      end
    end else begin
      slot_s   = 1'b0;
      target_s = 8'd0;
    end
    if (slot_s) begin
      start_s = !prefetch_busy_i;
      drop_s  = prefetch_busy_i;
    end else begin
      start_s = 1'b0;
      drop_s  = 1'b0;
    end
    if (start_s) begin
      prefetch_y_s = target_s;
    end else begin
      prefetch_y_s = 8'd0;
    end
  end

  // Saturating count of suppressed requests
  always_ff @(posedge gpu_clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_count_r <= 8'd0;
    end else if (drop_s && (drop_count_r != DROP_MAX)) begin
      drop_count_r <= drop_count_r + 8'd1;
    end else begin
      drop_count_r <= drop_count_r;
    end
  end

  assign prefetch_start_o = start_s;
  assign prefetch_y_o     = prefetch_y_s;
  assign display_x_o      = x_s;
  assign display_y_o      = y_s;
  assign visible_o        = visible_s;
  assign hsync_o          = hsync_s;
  assign vsync_o          = vsync_s;
  assign drop_o           = drop_s;
  assign drop_count_o     = drop_count_r;

  foreground_prefetch_scheduler_chk #(
    .H_TOTAL (H_TOTAL),
    .V_TOTAL (V_TOTAL)
  ) u_chk (
    .gpu_clk (gpu_clk),
    .rst_n   (rst_n),
    .h       (h_r),
    .v       (v_r),
    .start   (start_s),
    .start_y (prefetch_y_s),
    .drop    (drop_s)
  );
endmodule

// File: tb/tb_foreground_prefetch_scheduler.sv
// Bench for foreground_prefetch_scheduler: table vectors and a cycle-count reference model
// on a default-sized instance, plus a mid-pulse reset instance and a small saturation instance.
module tb_foreground_prefetch_scheduler;
  localparam int HV = 256, HF = 8, HS = 32, HB = 24;
  localparam int VV = 240, VF = 3, VS = 4, VB = 15;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int FRAME = HT * VT;
  localparam int SHV = 8, SHF = 2, SHS = 3, SHB = 3;
  localparam int SVV = 6, SVF = 1, SVS = 1, SVB = 2;

  typedef struct { bit vis; int x; int y; bit hs; bit vs; bit slot; int target; } exp_t;
  typedef struct { int v; int h; int busy; int start; int py; int drop;
                   int vis; int x; int y; int hs; int vs; int dc; } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  vec_t tbl[$];

  logic a_rst_n, a_busy, a_start, a_vis, a_hs, a_vs, a_drop;
  logic [7:0] a_py, a_x, a_y, a_dc;
  logic b_rst_n, b_busy, b_start, b_vis, b_hs, b_vs, b_drop;
  logic [7:0] b_py, b_x, b_y, b_dc;
  logic c_rst_n, c_busy, c_start, c_vis, c_hs, c_vs, c_drop;
  logic [7:0] c_py, c_x, c_y, c_dc;

  foreground_prefetch_scheduler u_a (
    .gpu_clk(clk), .rst_n(a_rst_n), .prefetch_busy_i(a_busy), .prefetch_start_o(a_start),
    .prefetch_y_o(a_py), .display_x_o(a_x), .display_y_o(a_y), .visible_o(a_vis),
    .hsync_o(a_hs), .vsync_o(a_vs), .drop_o(a_drop), .drop_count_o(a_dc));

  foreground_prefetch_scheduler u_b (
    .gpu_clk(clk), .rst_n(b_rst_n), .prefetch_busy_i(b_busy), .prefetch_start_o(b_start),
    .prefetch_y_o(b_py), .display_x_o(b_x), .display_y_o(b_y), .visible_o(b_vis),
    .hsync_o(b_hs), .vsync_o(b_vs), .drop_o(b_drop), .drop_count_o(b_dc));

  foreground_prefetch_scheduler #(
    .H_VISIBLE(SHV), .H_FRONT(SHF), .H_SYNC(SHS), .H_BACK(SHB),
    .V_VISIBLE(SVV), .V_FRONT(SVF), .V_SYNC(SVS), .V_BACK(SVB)
  ) u_c (
    .gpu_clk(clk), .rst_n(c_rst_n), .prefetch_busy_i(c_busy), .prefetch_start_o(c_start),
    .prefetch_y_o(c_py), .display_x_o(c_x), .display_y_o(c_y), .visible_o(c_vis),
    .hsync_o(c_hs), .vsync_o(c_vs), .drop_o(c_drop), .drop_count_o(c_dc));

  // Expected beam outputs t clocks after reset release, from the raster rules alone
  function automatic exp_t model(input int t, input int hv, hf, hs, hb, vv, vf, vs, vb);
    exp_t e;
    int ht, vt, h, v;
    ht = hv + hf + hs + hb;
    vt = vv + vf + vs + vb;
    h = t % ht;
    v = (t / ht) % vt;
    e.vis = (h < hv) && (v < vv);
    e.x = e.vis ? h : 0;
    e.y = e.vis ? v : 0;
    e.hs = !((h >= hv + hf) && (h < hv + hf + hs));
    e.vs = !((v >= vv + vf) && (v < vv + vf + vs));
    e.slot = (h == hv) && ((v + 1 < vv) || (v == vt - 1));
    e.target = e.slot ? ((v + 1) % vt) : 0;
    return e;
  endfunction

  function automatic bit outs_ok(input exp_t e, input int busy, input int dc_exp,
                                 input logic st, input logic [7:0] py, input logic dr,
                                 input logic vis, input logic [7:0] x, input logic [7:0] y,
                                 input logic hs, input logic vs, input logic [7:0] dc);
    bit es, ed;
    int epy;
    es = e.slot && (busy == 0);
    ed = e.slot && (busy != 0);
    epy = es ? e.target : 0;
    return (st == es) && (int'(py) == epy) && (dr == ed) && (vis == e.vis) &&
           (int'(x) == e.x) && (int'(y) == e.y) && (hs == e.hs) && (vs == e.vs) &&
           (int'(dc) == dc_exp);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_opt(input string name, input int act, input int want);
    if (want >= 0) check(name, act, want);
  endtask

  function automatic vec_t mk(input int v, h, busy, start, py, drop, vis, x, y, hs, vs, dc);
    vec_t r;
    r.v = v; r.h = h; r.busy = busy; r.start = start; r.py = py; r.drop = drop;
    r.vis = vis; r.x = x; r.y = y; r.hs = hs; r.vs = vs; r.dc = dc;
    return r;
  endfunction

  initial begin
    //           v    h   busy st  py  dr vis  x    y  hs  vs  dc
    tbl.push_back(mk(0,   0,   0, 0,  0, 0, 1,   0,   0, 1,  1,  0));
    tbl.push_back(mk(0,   255, 0, 0,  0, 0, 1, 255,   0, 1,  1, -1));
    tbl.push_back(mk(0,   256, 0, 1,  1, 0, 0,   0,   0, 1,  1, -1));
    tbl.push_back(mk(0,   263, 0, -1, -1, -1, -1, -1, -1, 1, -1, -1));
    tbl.push_back(mk(0,   264, 0, -1, -1, -1, -1, -1, -1, 0, -1, -1));
    tbl.push_back(mk(0,   295, 0, -1, -1, -1, -1, -1, -1, 0, -1, -1));
    tbl.push_back(mk(0,   296, 0, -1, -1, -1, -1, -1, -1, 1, -1, -1));
    tbl.push_back(mk(5,   256, 1, 0,  0, 1, 0,   0,   0, 1,  1,  0));
    tbl.push_back(mk(5,   257, 1, 0,  0, 0, 0,   0,   0, 1,  1,  1));
    tbl.push_back(mk(10,  20,  0, 0,  0, 0, 1,  20,  10, 1,  1, -1));
    tbl.push_back(mk(10,  300, 0, 0,  0, 0, 0,   0,   0, 1,  1, -1));
    tbl.push_back(mk(238, 256, 0, 1, 239, 0, 0,  0,   0, 1,  1, -1));
    tbl.push_back(mk(239, 255, 0, 0,  0, 0, 1, 255, 239, 1,  1, -1));
    tbl.push_back(mk(239, 256, 1, 0,  0, 0, 0,   0,   0, 1,  1, -1));
    tbl.push_back(mk(240, 0,   0, 0,  0, 0, 0,   0,   0, 1,  1, -1));
    tbl.push_back(mk(242, 319, 0, -1, -1, -1, -1, -1, -1, -1, 1, -1));
    tbl.push_back(mk(243, 0,   0, -1, -1, -1, -1, -1, -1, -1, 0, -1));
    tbl.push_back(mk(246, 319, 0, -1, -1, -1, -1, -1, -1, -1, 0, -1));
    tbl.push_back(mk(247, 0,   0, -1, -1, -1, -1, -1, -1, -1, 1, -1));
    tbl.push_back(mk(261, 256, 0, 1,  0, 0, 0,   0,   0, 1,  1, -1));

    a_rst_n = 1'b0; b_rst_n = 1'b0; c_rst_n = 1'b0;
    a_busy = 1'b1; b_busy = 1'b0; c_busy = 1'b0;
    #12;
    check("reset visible", a_vis, 1);
    check("reset display_x", a_x, 0);
    check("reset display_y", a_y, 0);
    check("reset hsync", a_hs, 1);
    check("reset vsync", a_vs, 1);
    check("reset start", a_start, 0);
    check("reset prefetch_y", a_py, 0);
    check("reset drop", a_drop, 0);
    check("reset drop_count", a_dc, 0);
    @(negedge clk);
    a_rst_n = 1'b1; b_rst_n = 1'b1; c_rst_n = 1'b1;

    fork
      begin : proc_a
        int dc_exp, nd, pulses, drops, exp_pulses;
        int hs_cnt, hs_first, hs_last, vs_cnt, vs_first, vs_last, f1_pulse;
        dc_exp = 0; nd = 0; pulses = 0; drops = 0; exp_pulses = 0;
        hs_cnt = 0; hs_first = -1; hs_last = -1;
        vs_cnt = 0; vs_first = -1; vs_last = -1; f1_pulse = -1;
        for (int t = 0; t < FRAME + HT; t++) begin
          int h, v, busy, idx;
          exp_t e;
          h = t % HT;
          v = (t / HT) % VT;
          idx = -1;
          if (t < FRAME) foreach (tbl[i]) if (tbl[i].v == v && tbl[i].h == h) idx = i;
          if (idx >= 0) busy = tbl[idx].busy;
          else if (t < FRAME && v >= 120 && v < 238) busy = int'($urandom_range(0, 1));
          else busy = 0;
          a_busy = busy[0];
          #1;
          e = model(t, HV, HF, HS, HB, VV, VF, VS, VB);
          if (!outs_ok(e, busy, dc_exp, a_start, a_py, a_drop, a_vis, a_x, a_y, a_hs, a_vs, a_dc)) begin
            nd++;
            if (nd <= 8) $display("note: A cycle %0d (v=%0d h=%0d) diverges from model", t, v, h);
          end
          if (idx >= 0) begin
            check_opt($sformatf("tbl[%0d] start", idx), a_start, tbl[idx].start);
            check_opt($sformatf("tbl[%0d] prefetch_y", idx), a_py, tbl[idx].py);
            check_opt($sformatf("tbl[%0d] drop", idx), a_drop, tbl[idx].drop);
            check_opt($sformatf("tbl[%0d] visible", idx), a_vis, tbl[idx].vis);
            check_opt($sformatf("tbl[%0d] display_x", idx), a_x, tbl[idx].x);
            check_opt($sformatf("tbl[%0d] display_y", idx), a_y, tbl[idx].y);
            check_opt($sformatf("tbl[%0d] hsync", idx), a_hs, tbl[idx].hs);
            check_opt($sformatf("tbl[%0d] vsync", idx), a_vs, tbl[idx].vs);
            check_opt($sformatf("tbl[%0d] drop_count", idx), a_dc, tbl[idx].dc);
          end
          if (t < FRAME) begin
            pulses += int'(a_start);
            drops += int'(a_drop);
            exp_pulses += (e.slot && busy == 0) ? 1 : 0;
            if (t < HT && !a_hs) begin
              hs_cnt++;
              if (hs_first < 0) hs_first = h;
              hs_last = h;
            end
            if (!a_vs) begin
              vs_cnt++;
              if (vs_first < 0) vs_first = v;
              vs_last = v;
            end
          end else if (a_start && f1_pulse < 0) begin
            f1_pulse = t;
          end
          if (e.slot && busy != 0) dc_exp = (dc_exp < 255) ? dc_exp + 1 : 255;
          @(negedge clk);
        end
        check("A cycles diverging from model", nd, 0);
        check("A frame pulses", pulses, exp_pulses);
        check("A frame pulses+drops", pulses + drops, 240);
        check("A final drop_count", a_dc, dc_exp);
        check("A hsync low clocks line 0", hs_cnt, 32);
        check("A hsync first low h", hs_first, 264);
        check("A hsync last low h", hs_last, 295);
        check("A vsync low clocks", vs_cnt, 4 * HT);
        check("A vsync first low v", vs_first, 243);
        check("A vsync last low v", vs_last, 246);
        check("A first pulse of frame 1 at clock", f1_pulse, FRAME + 256);
      end

      begin : proc_b
        int early, x1;
        early = 0; x1 = -1;
        for (int t = 0; t < 100 * HT + 256; t++) begin
          b_busy = ((t / HT) == 3) ? 1'b1 : 1'b0;
          @(negedge clk);
        end
        b_busy = 1'b0;
        #1;
        check("B pulse at v=100 start", b_start, 1);
        check("B pulse at v=100 prefetch_y", b_py, 101);
        check("B drop_count before reset", b_dc, 1);
        #2 b_rst_n = 1'b0;
        #1;
        check("B async reset start", b_start, 0);
        check("B async reset prefetch_y", b_py, 0);
        check("B async reset display_x", b_x, 0);
        check("B async reset display_y", b_y, 0);
        check("B async reset visible", b_vis, 1);
        check("B async reset hsync", b_hs, 1);
        check("B async reset vsync", b_vs, 1);
        check("B async reset drop_count", b_dc, 0);
        b_busy = 1'b1;
        @(negedge clk);
        #1;
        check("B held reset display_x", b_x, 0);
        check("B held reset drop", b_drop, 0);
        b_busy = 1'b0;
        b_rst_n = 1'b1;
        for (int t = 0; t <= 256; t++) begin
          if (t == 1) x1 = b_x;
          if (t < 256 && b_start) early++;
          if (t == 256) begin
            check("B first pulse after reset start", b_start, 1);
            check("B first pulse after reset prefetch_y", b_py, 1);
          end
          @(negedge clk);
          #1;
        end
        check("B display_x one clock after release", x1, 1);
        check("B pulses before h=256 after release", early, 0);
      end

      begin : proc_c
        int dc_exp, nd, held, stuck, reached;
        dc_exp = 0; nd = 0; held = 0; stuck = 0; reached = 0;
        for (int t = 0; t < 1600 + 9000; t++) begin
          exp_t e;
          int busy;
          if (t >= 1600 && held >= 300) break;
          busy = (t < 1600) ? int'($urandom_range(0, 1)) : 1;
          c_busy = busy[0];
          #1;
          e = model(t, SHV, SHF, SHS, SHB, SVV, SVF, SVS, SVB);
          if (!outs_ok(e, busy, dc_exp, c_start, c_py, c_drop, c_vis, c_x, c_y, c_hs, c_vs, c_dc)) begin
            nd++;
            if (nd <= 8) $display("note: C cycle %0d diverges from model", t);
          end
          if (t >= 1600 && c_drop) held++;
          if (reached != 0 && c_dc != 8'd255) stuck++;
          if (c_dc == 8'd255) reached = 1;
          if (e.slot && busy != 0) dc_exp = (dc_exp < 255) ? dc_exp + 1 : 255;
          @(negedge clk);
        end
        #1;
        check("C cycles diverging from model", nd, 0);
        check("C busy slots dropped", held, 300);
        check("C saturated drop_count", c_dc, 255);
        check("C drop_count left 255 after reaching it", stuck, 0);
      end
    join

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/foreground_prefetch_scheduler.md
FOREGROUND_PREFETCH_SCHEDULER -- requirements
Module: foreground_prefetch_scheduler

Interface
REQ-001 SHALL have parameter H_VISIBLE, default 256, visible pixels per line.
REQ-002 SHALL have parameter H_FRONT, default 8, horizontal front porch in clocks.
REQ-003 SHALL have parameter H_SYNC, default 32, horizontal sync width in clocks.
REQ-004 SHALL have parameter H_BACK, default 24, horizontal back porch in clocks; H_TOTAL = sum of the four horizontal parameters = 320.
REQ-005 SHALL have parameter V_VISIBLE, default 240, visible lines per frame.
REQ-006 SHALL have parameters V_FRONT, default 3; V_SYNC, default 4; V_BACK, default 15; V_TOTAL = sum of the four vertical parameters = 262.
REQ-007 SHALL have port gpu_clk, input, 1, sole clock; all state changes on the rising edge.
REQ-008 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-009 SHALL have port prefetch_busy_i, input, 1, foreground prefetch unit not idle.
REQ-010 SHALL have port prefetch_start_o, output, 1, one-cycle prefetch request pulse.
REQ-011 SHALL have port prefetch_y_o, output, 8, scanline to prefetch; valid while prefetch_start_o=1.
REQ-012 SHALL have ports display_x_o and display_y_o, output, 8 each, current visible pixel coordinate.
REQ-013 SHALL have port visible_o, output, 1, current pixel inside the visible area.
REQ-014 SHALL have ports hsync_o and vsync_o, output, 1 each, active-low sync.
REQ-015 SHALL have port drop_o, output, 1, one-cycle pulse when a scheduled prefetch was suppressed.
REQ-016 SHALL have port drop_count_o, output, 8, count of suppressed prefetches since reset.

Function
REQ-017 SHALL keep a 9-bit h counter h running 0..H_TOTAL-1, wrapping to 0.
REQ-018 SHALL keep a 9-bit v counter v that increments only when h wraps, running 0..V_TOTAL-1, wrapping to 0.
REQ-019 SHALL drive visible_o = (h < H_VISIBLE) and (v < V_VISIBLE), combinationally from the counters with no added latency.
REQ-020 SHALL drive display_x_o = h[7:0] and display_y_o = v[7:0] when visible_o=1; both SHALL be 0 otherwise.
REQ-021 SHALL drive hsync_o=0 when H_VISIBLE+H_FRONT <= h < H_VISIBLE+H_FRONT+H_SYNC, else 1.
REQ-022 SHALL drive vsync_o=0 when V_VISIBLE+V_FRONT <= v < V_VISIBLE+V_FRONT+V_SYNC, else 1.
REQ-023 SHALL define a scheduled prefetch slot as the cycle with h == H_VISIBLE and either v+1 < V_VISIBLE (target v+1) or v == V_TOTAL-1 (target 0).
REQ-024 SHALL, in a slot with prefetch_busy_i=0, assert prefetch_start_o for exactly that cycle with prefetch_y_o = target.
REQ-025 SHALL, in a slot with prefetch_busy_i=1, keep prefetch_start_o=0, pulse drop_o for that cycle, and increment drop_count_o on the following edge.
REQ-026 SHALL saturate drop_count_o at 255; it SHALL never wrap.
REQ-027 SHALL hold prefetch_start_o=0 and drop_o=0 outside slots regardless of prefetch_busy_i.
REQ-028 SHALL drive prefetch_y_o = 0 when prefetch_start_o=0.
REQ-029 SHALL never issue a slot on lines V_VISIBLE-1 through V_TOTAL-2; at most one request per line and exactly V_VISIBLE requests per frame when never busy.

Reset
REQ-030 SHALL, while rst_n=0, force h=0, v=0, and drop_count_o=0 immediately and asynchronously.
REQ-031 SHALL, during reset, present visible_o=1, display_x_o=0, display_y_o=0, hsync_o=1, vsync_o=1, prefetch_start_o=0, prefetch_y_o=0, drop_o=0.
REQ-032 SHALL resume counting from (h=0,v=0) on the first rising edge after rst_n deasserts; reset mid-line or mid-frame SHALL abandon the frame with no partial prefetch pulse.

Verification
REQ-033 SHALL verify free run from reset, never busy: hsync_o low for h=264..295 exactly; vsync_o low for v=243..246 exactly; one frame = 83840 clocks.
REQ-034 SHALL verify prefetch schedule: (v=0,h=256) -> start with y=1; (v=238,h=256) -> y=239; (v=239,h=256) -> no pulse; (v=261,h=256) -> y=0; 240 pulses per frame.
REQ-035 SHALL verify busy in slot at (v=5,h=256) -> no prefetch_start_o, drop_o=1 for one cycle, drop_count_o 0 -> 1; busy at h=257 -> no effect.
REQ-036 SHALL verify saturation: busy held for 300 slots -> drop_count_o reaches 255 and stays 255.
REQ-037 SHALL verify asynchronous reset at (v=100,h=256) mid-pulse -> prefetch_start_o falls without waiting for a clock edge, counters read (0,0), drop_count_o=0.
REQ-038 SHALL verify display coordinates: (v=10,h=20) -> (20,10), visible_o=1; (v=10,h=300) -> (0,0), visible_o=0.
